// File: rtl/complex_mul_seq.sv
// complex_mul_seq: sequenced complex multiplier, (ar + j*ai) * (br + j*bi),
// sharing one W x W unsigned multiplier across four cycles.
// Optional feature macro: CMUL_CONJ_EN adds a 'conj' input that multiplies
// by the conjugate of B instead.
// Packing: a/b = {real, imag} (W bits each); product = {real, imag} (2W bits each).
// Real and imaginary results wrap modulo 2^(2W); there is no saturation.
module complex_mul_seq #(
    parameter int W = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*W-1:0] a,
    input  logic [2*W-1:0] b,
`ifdef CMUL_CONJ_EN
    input  logic           conj,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*W-1:0] product,
    output logic           busy
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        M_RR = 3'd1,
        M_II = 3'd2,
        M_RI = 3'd3,
        M_IR = 3'd4,
        DONE = 3'd5
    } state_t;

    state_t         r_state;
    state_t         w_next;

    logic [2*W-1:0] r_a;
    logic [2*W-1:0] r_b;
    logic [2*W-1:0] r_acc_re;
    logic [2*W-1:0] r_acc_im;

    logic [W-1:0]   w_ar, w_ai, w_br, w_bi;
    logic [W-1:0]   w_mul_x;
    logic [W-1:0]   w_mul_y;
    logic [2*W-1:0] w_prod;
    logic           w_accept;
    logic           w_conj;

`ifdef CMUL_CONJ_EN
    logic           r_conj;
    assign w_conj = r_conj;
`else
    assign w_conj = 1'b0;
`endif

    assign w_ar = r_a[2*W-1:W];
    assign w_ai = r_a[W-1:0];
    assign w_br = r_b[2*W-1:W];
    assign w_bi = r_b[W-1:0];

    // The single shared multiplier; both operands zero-extended to the full 2W-bit product.
    assign w_prod   = {{W{1'b0}}, w_mul_x} * {{W{1'b0}}, w_mul_y};
    assign w_accept = in_valid && in_ready;
    assign product  = {r_acc_re, r_acc_im};

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state, handshake outputs and multiplier operand selection by state.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        w_mul_x   = '0;
        w_mul_y   = '0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    w_next = M_RR;
                end
            end
            M_RR: begin
                w_mul_x = w_ar;
                w_mul_y = w_br;
                w_next  = M_II;
            end
            M_II: begin
                w_mul_x = w_ai;
                w_mul_y = w_bi;
                w_next  = M_RI;
            end
            M_RI: begin
                w_mul_x = w_ar;
                w_mul_y = w_bi;
                w_next  = M_IR;
            end
            M_IR: begin
                w_mul_x = w_ai;
                w_mul_y = w_br;
                w_next  = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = IDLE;
                end
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Operand capture on accept and the real/imag accumulation sequence.
    // Conjugating B flips the sign of bi: the ai*bi term adds and ar*bi starts negative.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a      <= '0;
            r_b      <= '0;
            r_acc_re <= '0;
            r_acc_im <= '0;
`ifdef CMUL_CONJ_EN
            r_conj   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a <= a;
                        r_b <= b;
`ifdef CMUL_CONJ_EN
                        r_conj <= conj;
`endif
                    end
                end
                M_RR: r_acc_re <= w_prod;
                M_II: r_acc_re <= w_conj ? (r_acc_re + w_prod) : (r_acc_re - w_prod);
                M_RI: r_acc_im <= w_conj ? ({2*W{1'b0}} - w_prod) : w_prod;
                M_IR: r_acc_im <= r_acc_im + w_prod;
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_complex_mul_seq.sv
// Directed self-checking bench for complex_mul_seq (W = 8).
// Inputs change and outputs are sampled 1 ns after the rising edge.
module tb_complex_mul_seq;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        conj;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int checks;
    int failures;

    complex_mul_seq #(.W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef CMUL_CONJ_EN
        .conj      (conj),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present operands from an IDLE cycle; returns 1 ns after the accept edge.
    task automatic drive_accept(input logic [15:0] va, input logic [15:0] vb, input logic vc);
        a = va;
        b = vb;
        conj = vc;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++; if (product !== 32'h0) begin failures++; $display("FAIL reset_product got=%h want=00000000", product); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Runs one operation with out_ready high and checks latency, value and a one-cycle valid pulse.
    task automatic run_single(input string name, input logic [15:0] va, input logic [15:0] vb,
                              input logic vc, input logic [31:0] want);
        out_ready = 1'b1;
        drive_accept(va, vb, vc);
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++;
            $display("FAIL %s_busy_after_accept got busy=%b in_ready=%b want busy=1 in_ready=0", name, busy, in_ready); end
        for (int k = 1; k <= 3; k++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin failures++;
                $display("FAIL %s_early_valid edge=%0d got=%b want=0", name, k, out_valid); end
        end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL %s_valid got=%b want=1", name, out_valid); end
        checks++; if (product !== want) begin failures++; $display("FAIL %s_product got=%h want=%h", name, product, want); end
        @(posedge clk); #1;
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failures++;
            $display("FAIL %s_return_idle got out_valid=%b in_ready=%b want 0/1", name, out_valid, in_ready); end
    endtask

    task automatic test_basic();
        run_single("basic", 16'h0302, 16'h0105, 1'b0, 32'hFFF9_0011);
    endtask

    task automatic test_wrap();
        run_single("wrap", 16'hFFFF, 16'hFFFF, 1'b0, 32'h0000_FC02);
    endtask

    task automatic test_backpressure();
        logic [31:0] held;
        int bad_stable, bad_ready, bad_valid;
        out_ready = 1'b0;
        drive_accept(16'h0302, 16'h0105, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_valid got=%b want=1", out_valid); end
        held = product;
        checks++; if (held !== 32'hFFF9_0011) begin failures++; $display("FAIL bp_product got=%h want=fff90011", held); end
        a = 16'h0101; b = 16'h0101; in_valid = 1'b1;
        bad_stable = 0; bad_ready = 0; bad_valid = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (product !== 32'hFFF9_0011) bad_stable++;
            if (in_ready !== 1'b0) bad_ready++;
            if (out_valid !== 1'b1) bad_valid++;
        end
        checks++; if (bad_stable != 0) begin failures++; $display("FAIL bp_hold_product bad_cycles=%0d want=0", bad_stable); end
        checks++; if (bad_ready != 0) begin failures++; $display("FAIL bp_in_ready_low bad_cycles=%0d want=0", bad_ready); end
        checks++; if (bad_valid != 0) begin failures++; $display("FAIL bp_valid_held bad_cycles=%0d want=0", bad_valid); end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin failures++;
            $display("FAIL bp_release got in_ready=%b out_valid=%b busy=%b want 1/0/0", in_ready, out_valid, busy); end
        run_single("bp_next", 16'h0102, 16'h0304, 1'b0, 32'hFFFB_000A);
    endtask

    task automatic test_reset_midop();
        int stale;
        out_ready = 1'b1;
        drive_accept(16'h0302, 16'h0105, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL midrst_busy got=%b want=0", busy); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
        checks++; if (product !== 32'h0) begin failures++; $display("FAIL midrst_product got=%h want=00000000", product); end
        stale = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) stale++;
        end
        checks++; if (stale != 0) begin failures++; $display("FAIL midrst_stale_valid cycles=%0d want=0", stale); end
    endtask

`ifdef CMUL_CONJ_EN
    task automatic test_conj();
        run_single("conj1", 16'h0302, 16'h0105, 1'b1, 32'h000D_FFF3);
        run_single("conj0", 16'h0302, 16'h0105, 1'b0, 32'hFFF9_0011);
    endtask
`endif

    task automatic test_back_to_back();
        logic [15:0] va [4];
        logic [15:0] vb [4];
        logic [31:0] want [4];
        logic [31:0] prod_now;
        logic acc_now, hs_now;
        int n_in, n_out, last, extra;
        va[0] = 16'h0302; vb[0] = 16'h0105; want[0] = 32'hFFF9_0011;
        va[1] = 16'hFFFF; vb[1] = 16'hFFFF; want[1] = 32'h0000_FC02;
        va[2] = 16'h0102; vb[2] = 16'h0304; want[2] = 32'hFFFB_000A;
        va[3] = 16'h1000; vb[3] = 16'h0010; want[3] = 32'h0000_0100;
        n_in = 0; n_out = 0; last = 0;
        out_ready = 1'b1;
        conj = 1'b0;
        a = va[0]; b = vb[0]; in_valid = 1'b1;
        for (int cyc = 0; cyc < 60 && n_out < 4; cyc++) begin
            acc_now  = in_valid && in_ready;
            hs_now   = out_valid && out_ready;
            prod_now = product;
            @(posedge clk); #1;
            if (hs_now) begin
                checks++; if (prod_now !== want[n_out]) begin failures++;
                    $display("FAIL b2b_product idx=%0d got=%h want=%h", n_out, prod_now, want[n_out]); end
                if (n_out > 0) begin
                    checks++; if (cyc - last != 6) begin failures++;
                        $display("FAIL b2b_spacing idx=%0d got=%0d want=6", n_out, cyc - last); end
                end
                last = cyc;
                n_out++;
            end
            if (acc_now) begin
                n_in++;
                if (n_in < 4) begin
                    a = va[n_in]; b = vb[n_in];
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        in_valid = 1'b0;
        checks++; if (n_out != 4) begin failures++; $display("FAIL b2b_result_count got=%0d want=4", n_out); end
        checks++; if (n_in != 4) begin failures++; $display("FAIL b2b_accept_count got=%0d want=4", n_in); end
        extra = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0) extra++;
        end
        checks++; if (extra != 0) begin failures++; $display("FAIL b2b_extra_valid cycles=%0d want=0", extra); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        a = '0;
        b = '0;
        conj = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_reset_midop();
`ifdef CMUL_CONJ_EN
        test_conj();
`endif
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
